// File: rtl/mc_controller.sv
// mc_controller
// Multicycle control unit for a reduced RV32I subset (lw, sw, add/sub/and/or,
// addi/andi/ori, beq, jal). A Moore state machine walks each instruction
// through fetch, decode and execute states and drives the datapath enables
// and mux selects. A small ALU decoder turns the per-state ALU operation plus
// the instruction fields into the 2-bit datapath ALU code
// (00 AND, 01 OR, 10 ADD, 11 SUB).
//
// Ports
//   clk         in   sole clock, rising edge
//   reset       in   synchronous, active-high reset
//   op          in   instruction[6:0]
//   funct3      in   instruction[14:12]
//   funct7b5    in   instruction[30]
//   zero        in   ALU result == 0
//   PCWrite     out  PC register enable
//   AdrSrc      out  memory address select (0 PC, 1 ALUOut)
//   MemWrite    out  data memory write enable
//   IRWrite     out  instruction register enable
//   ResultSrc   out  result select (00 ALUOut, 01 Data, 10 ALU result)
//   ALUSrcA     out  A select (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB     out  B select (00 rs2, 01 ImmExt, 10 constant 4)
//   RegWrite    out  register file write enable
//   ImmSrc      out  immediate format (00 I, 01 S, 10 B, 11 J)
//   ALUControl  out  ALU operation
//   illegal     out  one-cycle pulse when decode rejects an instruction
//   halted      out  high while halted
module mc_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl,
  output logic       illegal,
  output logic       halted
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  } aluop_t;

  state_t state;
  aluop_t aluOp;

  logic isLw, isSw, isR, isI, isBeq, isJal;
  logic knownOp, legalF3, illegalInstr;

  // Opcode classification and legality. Only R-type and I-type care about
  // funct3; loads and stores accept any funct3 since the datapath only moves
  // whole words.
  always_comb begin
    isLw    = (op == OP_LW);
    isSw    = (op == OP_SW);
    isR     = (op == OP_R);
    isI     = (op == OP_I);
    isBeq   = (op == OP_BEQ);
    isJal   = (op == OP_JAL);
    knownOp = isLw | isSw | isR | isI | isBeq | isJal;
    legalF3 = (funct3 == 3'b000) | (funct3 == 3'b110) | (funct3 == 3'b111);
    illegalInstr = !knownOp || ((isR || isI) && !legalF3);
  end

  // Immediate format depends only on the opcode and is valid in every state,
  // including reset, so the extender is always ready before it is needed.
  always_comb begin
    ImmSrc = 2'b00;
    if (isSw)       ImmSrc = 2'b01;
    else if (isBeq) ImmSrc = 2'b10;
    else if (isJal) ImmSrc = 2'b11;
  end

  // State register with the whole next-state function. Decode is the only
  // branching point; memory address chooses read or write from the opcode,
  // and halt is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    state <= S_DECODE;
        S_DECODE: begin
          if (illegalInstr)       state <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          else if (isLw || isSw)  state <= S_MEMADR;
          else if (isR)           state <= S_EXECR;
          else if (isI)           state <= S_EXECI;
          else if (isJal)         state <= S_JAL;
          else                    state <= S_BEQ;
        end
        S_MEMADR:   state <= isLw ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_BEQ:      state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode. Everything defaults to zero with an ADD ALU op;
  // each state only overrides what it uses. Reset wins over the state so no
  // write enable can fire while reset is held, and the selects show the fetch
  // setup so the datapath is already pointed at the PC.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    aluOp     = ALUOP_ADD;
    illegal   = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        illegal = illegalInstr;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        aluOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        aluOp   = ALUOP_SUB;
        PCWrite = zero;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
    if (reset) begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b10;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b10;
      RegWrite  = 1'b0;
      aluOp     = ALUOP_ADD;
      illegal   = 1'b0;
      halted    = 1'b0;
    end
  end

  // ALU decoder. Subtraction from funct3 000 is only for R-type with
  // funct7b5 set; addi carries immediate bits there and must stay ADD.
  // Unsupported funct3 never reaches execute, so it simply falls to ADD.
  always_comb begin
    ALUControl = 2'b10;
    case (aluOp)
      ALUOP_SUB: ALUControl = 2'b11;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (isR && funct7b5) ? 2'b11 : 2'b10;
          3'b111:  ALUControl = 2'b00;
          3'b110:  ALUControl = 2'b01;
          default: ALUControl = 2'b10;
        endcase
      end
      default: ALUControl = 2'b10;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
// Drives two controllers (halt-on-illegal and return-to-fetch) from the same
// instruction stream. For each instruction the bench builds the list of
// per-cycle outputs the instruction must produce, then steps the clock and a
// single compare process checks both controllers every cycle. A few literal
// expectations pin down the directed instructions.
module tb_mc_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic       rw;
    logic [1:0] imm;
    logic [1:0] alu;
    logic       ill;
    logic       hlt;
  } outs_t;

  typedef struct {
    outs_t e0;
    outs_t e1;
    bit    zf;
    bit    rst;
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;

  logic       PCWrite0, AdrSrc0, MemWrite0, IRWrite0, RegWrite0, illegal0, halted0;
  logic [1:0] ResultSrc0, ALUSrcA0, ALUSrcB0, ImmSrc0, ALUControl0;
  logic       PCWrite1, AdrSrc1, MemWrite1, IRWrite1, RegWrite1, illegal1, halted1;
  logic [1:0] ResultSrc1, ALUSrcA1, ALUSrcB1, ImmSrc1, ALUControl1;

  outs_t act0, act1;
  assign act0 = {PCWrite0, AdrSrc0, MemWrite0, IRWrite0, ResultSrc0, ALUSrcA0,
                 ALUSrcB0, RegWrite0, ImmSrc0, ALUControl0, illegal0, halted0};
  assign act1 = {PCWrite1, AdrSrc1, MemWrite1, IRWrite1, ResultSrc1, ALUSrcA1,
                 ALUSrcB1, RegWrite1, ImmSrc1, ALUControl1, illegal1, halted1};

  mc_controller #(.HALT_ON_ILLEGAL(1'b1)) dutHalt (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .PCWrite(PCWrite0), .AdrSrc(AdrSrc0), .MemWrite(MemWrite0),
    .IRWrite(IRWrite0), .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0),
    .ALUSrcB(ALUSrcB0), .RegWrite(RegWrite0), .ImmSrc(ImmSrc0),
    .ALUControl(ALUControl0), .illegal(illegal0), .halted(halted0)
  );

  mc_controller #(.HALT_ON_ILLEGAL(1'b0)) dutResume (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .PCWrite(PCWrite1), .AdrSrc(AdrSrc1), .MemWrite(MemWrite1),
    .IRWrite(IRWrite1), .ResultSrc(ResultSrc1), .ALUSrcA(ALUSrcA1),
    .ALUSrcB(ALUSrcB1), .RegWrite(RegWrite1), .ImmSrc(ImmSrc1),
    .ALUControl(ALUControl1), .illegal(illegal1), .halted(halted1)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  int    cycle = 0;
  bit    checkEn = 1'b0;
  int    zeroMode = 2;
  step_t cur;
  step_t plan[$];
  outs_t log0[$];
  outs_t log1[$];
  logic [6:0] instOp = 7'b0;
  logic [2:0] instF3 = 3'b0;
  logic       instF7 = 1'b0;

  // Reference rules, written straight from the instruction-set table.
  function automatic logic [1:0] immFor(input logic [6:0] o);
    case (o)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] aluFunct(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b111) return 2'b00;
    if (f3 == 3'b110) return 2'b01;
    return (o == OP_R && f7) ? 2'b11 : 2'b10;
  endfunction

  function automatic bit isLegal(input logic [6:0] o, input logic [2:0] f3);
    bit f3ok;
    f3ok = (f3 == 3'b000) || (f3 == 3'b110) || (f3 == 3'b111);
    if (o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_JAL) return 1'b1;
    if (o == OP_R || o == OP_I) return f3ok;
    return 1'b0;
  endfunction

  function automatic outs_t vec(input logic pcw, input logic adr, input logic mw,
                                input logic irw, input logic [1:0] rs,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic rw, input logic [1:0] alu,
                                input logic ill, input logic hlt);
    outs_t v;
    v.pcw = pcw; v.adr = adr; v.mw = mw; v.irw = irw; v.rs = rs; v.a = a;
    v.b = b; v.rw = rw; v.imm = 2'b00; v.alu = alu; v.ill = ill; v.hlt = hlt;
    return v;
  endfunction

  function automatic outs_t fetchV();
    return vec(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 2'b10, 0, 0);
  endfunction
  function automatic outs_t resetV();
    return vec(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 2'b10, 0, 0);
  endfunction
  function automatic outs_t haltV();
    return vec(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 0, 1);
  endfunction
  function automatic outs_t decodeV(input logic ill);
    return vec(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b10, ill, 0);
  endfunction
  function automatic outs_t aluWbV();
    return vec(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b10, 0, 0);
  endfunction

  function automatic void addStep(input outs_t e0, input outs_t e1, input bit zf, input bit rst);
    step_t s;
    s.e0 = e0; s.e1 = e1; s.zf = zf; s.rst = rst;
    plan.push_back(s);
  endfunction

  function automatic void addSame(input outs_t e, input bit zf);
    addStep(e, e, zf, 1'b0);
  endfunction

  function automatic void addReset(input int n);
    for (int i = 0; i < n; i++) addStep(resetV(), resetV(), 1'b0, 1'b1);
  endfunction

  // Expected cycle-by-cycle outputs of one instruction, from fetch to the
  // last state. An illegal instruction keeps one controller halted while the
  // other loops fetch/decode on the same word, until a reset clears both.
  function automatic void planInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    int n;
    instOp = o; instF3 = f3; instF7 = f7;
    addSame(fetchV(), 1'b0);
    if (!isLegal(o, f3)) begin
      addSame(decodeV(1'b1), 1'b0);
      n = $urandom_range(2, 5);
      for (int k = 0; k < n; k++)
        addStep(haltV(), (k % 2 == 0) ? fetchV() : decodeV(1'b1), 1'b0, 1'b0);
      addReset($urandom_range(1, 2));
      return;
    end
    addSame(decodeV(1'b0), 1'b0);
    case (o)
      OP_LW: begin
        addSame(vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b10, 0, 0), 1'b0);
        addSame(vec(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 0, 0), 1'b0);
        addSame(vec(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b10, 0, 0), 1'b0);
      end
      OP_SW: begin
        addSame(vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b10, 0, 0), 1'b0);
        addSame(vec(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 0, 0), 1'b0);
      end
      OP_R: begin
        addSame(vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, aluFunct(o, f3, f7), 0, 0), 1'b0);
        addSame(aluWbV(), 1'b0);
      end
      OP_I: begin
        addSame(vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, aluFunct(o, f3, f7), 0, 0), 1'b0);
        addSame(aluWbV(), 1'b0);
      end
      OP_JAL: begin
        addSame(vec(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b10, 0, 0), 1'b0);
        addSame(aluWbV(), 1'b0);
      end
      default: begin
        addSame(vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b11, 0, 0), 1'b1);
      end
    endcase
  endfunction

  // Steps the clock once per planned cycle. Inputs change just after the
  // rising edge; outputs are captured just after the falling edge.
  task automatic applyStimulus();
    log0.delete();
    log1.delete();
    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      reset    = plan[i].rst;
      op       = instOp;
      funct3   = instF3;
      funct7b5 = instF7;
      zero     = (zeroMode == 2) ? 1'($urandom_range(0, 1)) : 1'(zeroMode);
      cur      = plan[i];
      checkEn  = 1'b1;
      @(negedge clk);
      #1;
      log0.push_back(act0);
      log1.push_back(act1);
    end
    plan.delete();
  endtask

  task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] req);
    vectors++;
    if (actual !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, req);
    end
  endtask

  // The per-cycle compare against the model for both controllers.
  always @(negedge clk) begin
    outs_t exp0, exp1;
    if (checkEn) begin
      cycle++;
      exp0 = cur.e0;
      exp1 = cur.e1;
      exp0.imm = immFor(op);
      exp1.imm = immFor(op);
      if (cur.zf) begin
        exp0.pcw = zero;
        exp1.pcw = zero;
      end
      vectors += 2;
      if (act0 !== exp0) begin
        miscompares++;
        $display("[TB] FAIL haltDut cycle %0d op=%b f3=%b: got %h, expected %h",
                 cycle, op, funct3, act0, exp0);
      end
      if (act1 !== exp1) begin
        miscompares++;
        $display("[TB] FAIL resumeDut cycle %0d op=%b f3=%b: got %h, expected %h",
                 cycle, op, funct3, act1, exp1);
      end
    end
  end

  // Directed instructions with literal expectations, then a random stream
  // with occasional mid-instruction resets.
  initial begin
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    int         cut;
    logic [2:0] goodF3 [3];
    goodF3[0] = 3'b000; goodF3[1] = 3'b110; goodF3[2] = 3'b111;

    addReset(2);
    applyStimulus();
    checkOutput("resetPCWrite", {1'b0, log0[0].pcw}, 2'b00);
    checkOutput("resetIRWrite", {1'b0, log0[1].irw}, 2'b00);
    checkOutput("resetRegMemWrite", {log0[1].rw, log0[1].mw}, 2'b00);

    planInstr(OP_LW, 3'b010, 1'b0);
    applyStimulus();
    checkOutput("firstFetchIRWrite", {log0[0].pcw, log0[0].irw}, 2'b11);
    checkOutput("firstFetchALUSrcB", log0[0].b, 2'b10);
    checkOutput("firstFetchALUControl", log0[0].alu, 2'b10);
    checkOutput("lwImmSrc", log0[2].imm, 2'b00);
    checkOutput("lwMemReadNoRegWrite", {log0[3].adr, log0[3].rw}, 2'b10);
    checkOutput("lwMemWbResultSrc", log0[4].rs, 2'b01);
    checkOutput("lwMemWbRegWrite", {1'b0, log0[4].rw}, 2'b01);

    planInstr(OP_R, 3'b000, 1'b1);
    applyStimulus();
    checkOutput("subALUControl", log0[2].alu, 2'b11);
    planInstr(OP_R, 3'b111, 1'b1);
    applyStimulus();
    checkOutput("andALUControl", log0[2].alu, 2'b00);
    planInstr(OP_R, 3'b110, 1'b0);
    applyStimulus();
    checkOutput("orALUControl", log0[2].alu, 2'b01);
    planInstr(OP_I, 3'b000, 1'b1);
    applyStimulus();
    checkOutput("addiALUControl", log0[2].alu, 2'b10);

    zeroMode = 1;
    planInstr(OP_BEQ, 3'b000, 1'b0);
    applyStimulus();
    checkOutput("beqTakenPCWrite", {1'b0, log0[2].pcw}, 2'b01);
    checkOutput("beqALUControl", log0[2].alu, 2'b11);
    checkOutput("beqImmSrc", log0[2].imm, 2'b10);
    zeroMode = 0;
    planInstr(OP_BEQ, 3'b000, 1'b0);
    applyStimulus();
    checkOutput("beqNotTakenPCWrite", {1'b0, log0[2].pcw}, 2'b00);
    zeroMode = 2;

    planInstr(OP_SW, 3'b010, 1'b0);
    applyStimulus();
    checkOutput("swMemAdrNoWrite", {1'b0, log0[2].mw}, 2'b00);
    checkOutput("swMemWrite", {log0[3].mw, log0[3].adr}, 2'b11);
    checkOutput("swImmSrc", log0[3].imm, 2'b01);
    planInstr(OP_JAL, 3'b000, 1'b0);
    applyStimulus();
    checkOutput("jalPCWrite", {1'b0, log0[2].pcw}, 2'b01);
    checkOutput("jalSrcs", {log0[2].a[0], log0[2].b[1]}, 2'b11);
    checkOutput("jalAluWbRegWrite", {1'b0, log0[3].rw}, 2'b01);

    planInstr(7'b1111111, 3'b000, 1'b0);
    applyStimulus();
    checkOutput("illegalPulse", {log0[1].ill, log0[2].ill}, 2'b10);
    checkOutput("haltedSticky", {log0[2].hlt, log0[3].hlt}, 2'b11);
    checkOutput("haltedNoEnables", {log0[3].pcw | log0[3].irw, log0[3].rw | log0[3].mw}, 2'b00);
    checkOutput("resumeFetch", {log1[2].irw, log1[2].hlt}, 2'b10);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: o = OP_LW;
        1: o = OP_SW;
        2, 3: o = OP_R;
        4, 5: o = OP_I;
        6: o = OP_BEQ;
        7: o = OP_JAL;
        8: o = 7'($urandom_range(0, 127));
        default: o = 7'b1111111;
      endcase
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : goodF3[$urandom_range(0, 2)];
      f7 = 1'($urandom_range(0, 1));
      planInstr(o, f3, f7);
      if ($urandom_range(0, 7) == 0) begin
        cut = $urandom_range(1, plan.size() - 1);
        plan = plan[0:cut-1];
        addReset($urandom_range(1, 2));
      end
      applyStimulus();
    end

    checkEn = 1'b0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit that drives the datapath's 2-bit ALU and register, memory and PC enables. It decodes the instruction register fields for a reduced RV32I subset: lw, sw, add/sub/and/or, addi/andi/ori, beq and jal. A Moore state machine sequences each instruction through fetch, decode and execute states. A small combinational ALU decoder produces `ALUControl` with the datapath encoding: 00 AND, 01 OR, 10 ADD, 11 SUB.

## Interface
- `HALT_ON_ILLEGAL`, default 1. Selects the next state after an illegal instruction: 1 enters HALT, 0 returns to FETCH.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  7  instruction[6:0], taken from the instruction register.
- `funct3`  in  3  instruction[14:12].
- `funct7b5`  in  1  instruction[30].
- `zero`  in  1  ALU result == 0.
- `PCWrite`  out  1  PC register enable.
- `AdrSrc`  out  1  memory address select: 0 PC, 1 ALUOut.
- `MemWrite`  out  1  data memory write enable.
- `IRWrite`  out  1  instruction register enable.
- `ResultSrc`  out  2  result select: 00 ALUOut, 01 Data, 10 ALU result.
- `ALUSrcA`  out  2  A select: 00 PC, 01 OldPC, 10 rs1 data.
- `ALUSrcB`  out  2  B select: 00 rs2 data, 01 ImmExt, 10 constant 4.
- `RegWrite`  out  1  register file write enable.
- `ImmSrc`  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- `ALUControl`  out  2  ALU operation.
- `illegal`  out  1  one-cycle pulse when DECODE rejects an instruction.
- `halted`  out  1  high while in HALT.

## Operation
- Opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-type 0010011
  - beq 1100011
  - jal 1101111
- `ImmSrc` is combinational from `op` in every state: lw/I-type 00, sw 01, beq 10, jal 11. Any other opcode gives 00.
- ALUOp is internal, set per state: ADD, SUB or FUNCT. When ALUOp is FUNCT, `ALUControl` is decoded from the instruction fields:
  - funct3 000: SUB (11) if op is R-type and funct7b5=1, otherwise ADD (10). addi is always ADD.
  - funct3 111: AND (00).
  - funct3 110: OR (01).
  - Any other funct3 is illegal.
- States and their Moore outputs. Any output not listed is 0. Any ALU-related output not listed defaults to ADD.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ADD (branch target). Next state by opcode:
    - lw or sw: MEMADR
    - R-type: EXECR
    - I-type: EXECI
    - jal: JAL
    - beq: BEQ
    - any other opcode, or an unsupported funct3 on R-type/I-type: pulse `illegal`, then go to HALT or FETCH according to `HALT_ON_ILLEGAL`.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ADD. Next state: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Next state: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next state: FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next state: FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, FUNCT. Next state: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, FUNCT. Next state: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next state: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1. Next state: ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00, PCWrite=`zero`. Next state: FETCH.
  - HALT: all enables 0, `halted`=1. Stays in HALT until `reset`.
- `funct7b5` is ignored for funct3 110 and 111.

## Timing
- Cycles per instruction, counting from FETCH through the last state:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq: 3
- All outputs are combinational from the state register, except two that also depend on inputs:
  - BEQ `PCWrite` follows `zero` in the same cycle.
  - DECODE `illegal` depends on `op` and `funct3`.
- `op`, `funct3` and `funct7b5` must be stable from DECODE until the instruction returns to FETCH. The instruction register guarantees this because it is written only in FETCH.
- While `reset`=1:
  - `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, `illegal` and `halted` are forced to 0.
  - The mux selects show their FETCH values.
  - The state register loads FETCH at the edge.
- The first cycle after `reset` deasserts is FETCH with full FETCH outputs.
- Reset asserted mid-instruction, including in HALT, aborts the instruction. The next state is FETCH, and no write enable is asserted while reset is high.

## Test plan
- Reset for 2 cycles, then release. Require: all enables 0 during reset; FETCH after release with IRWrite=1, PCWrite=1, ALUSrcB=10, ALUControl=10.
- lw (op 0000011). Require:
  - state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH;
  - ImmSrc=00;
  - RegWrite=1 only in the MEMWB cycle with ResultSrc=01.
- R-type with funct3 000, funct7b5=1 gives ALUControl=11 in EXECR. Repeat with funct3 111 (expect 00) and funct3 110 (expect 01). addi with funct7b5=1 gives 10.
- beq with zero=1: PCWrite=1 in BEQ, ALUControl=11, ImmSrc=10. Repeat with zero=0: PCWrite=0, and the next state is FETCH in both cases.
- sw followed by jal. Require:
  - MemWrite=1 exactly in MEMWRITE, ImmSrc=01;
  - jal: JAL state asserts PCWrite=1 with ALUSrcA=01, ALUSrcB=10, then ALUWB asserts RegWrite.
- op 1111111 with HALT_ON_ILLEGAL=1: illegal pulses 1 cycle in DECODE, halted=1 and stays set, all enables remain 0 until reset. With HALT_ON_ILLEGAL=0 the next state is FETCH.
